mem_stage_stack_unit: RTL and testbench
=======================================

// Module: mem_stage_stack_unit
// PURPOSE
//  MEM-stage data-memory front end. It sits directly downstream of the EX/MEM pipeline register.
//  Owns the word-addressed data RAM and the hardware stack pointer (SP).
//  Turns the {MemWriteM, PushM, PopM, MemSrcM} controls into RAM accesses.
//  ReadDataM goes to the MEM/WB register. Stack faults are flagged as sticky error bits for the hazard/exception logic.
// PARAMETERS
//  ADDR_W  8  word-address width; RAM depth DEPTH = 2**ADDR_W words of 32 bits
// PORTS
//  CLK         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-low
//  ALUResultM  in   32      byte address for normal load/store
//  WriteDataM  in   32      store/push data
//  MemWriteM   in   1       normal store enable
//  PushM       in   1       stack push request
//  PopM        in   1       stack pop request
//  MemSrcM     in   1       1 = stack addressing (SP), 0 = ALU addressing
//  ErrClr      in   1       synchronous clear of ErrM
//  ReadDataM   out  32      RAM read data (combinational, same cycle)
//  SPM         out  ADDR_W+1  current stack pointer (word units)
//  StackFull   out  1       SP == 0
//  StackEmpty  out  1       SP == DEPTH
//  ErrM        out  3       sticky {conflict, underflow, overflow}
// BEHAVIOUR
//  Reset (async, active-low)
//   - SP = DEPTH; ErrM = 3'b000; StackEmpty = 1; StackFull = 0.
//   - RAM contents are not reset.
//   - A write coinciding with reset assertion is discarded.
//  Stack model
//   - Full-descending stack. SP points at the last pushed word; SP == DEPTH means empty.
//   - SP is ADDR_W+1 bits wide so that it can hold DEPTH.
//  Address select
//   - MemSrcM = 0: word address = ALUResultM[ADDR_W+1:2]. Bits [1:0] and upper bits are ignored (wrap).
//   - MemSrcM = 1, push: word address = SP-1.
//   - MemSrcM = 1, otherwise: word address = SP[ADDR_W-1:0].
//  Reads
//   - ReadDataM = RAM[addr], combinational, zero latency.
//   - Pop on an empty stack returns ReadDataM = 0.
//  Normal store (MemSrcM = 0)
//   - MemWriteM = 1: RAM[addr] <= WriteDataM at the rising edge.
//   - PushM and PopM are ignored.
//  Stack operations (MemSrcM = 1; MemWriteM is ignored)
//   - Push, not full: RAM[SP-1] <= WriteDataM; SP <= SP-1.
//   - Push, full: no write; SP holds; set ErrM[0] (overflow).
//   - Pop, not empty: ReadDataM = RAM[SP]; SP <= SP+1.
//   - Pop, empty: SP holds; ReadDataM = 0; set ErrM[1] (underflow).
//   - PushM and PopM both 1: full no-op (no write, SP holds, ReadDataM = RAM[SP]); set ErrM[2] (conflict).
//  ErrM
//   - Bits are sticky; ErrClr clears all bits at the next edge.
//   - A set event in the same cycle as ErrClr wins: that bit reads 1 afterwards.
//  Flags
//   - StackFull and StackEmpty are decoded combinationally from the registered SP.
//  Pipeline flush
//   - A flush zeroes the EX/MEM controls upstream, so a flushed slot is a no-op here.
//   - The block needs no flush input.
//  Back-to-back operations
//   - Push then pop in consecutive cycles returns the pushed word.
//   - SP updates every cycle with no bubble.
// TESTING
//  T1 Reset
//   - Stimulus: assert reset mid-push (PushM = 1, MemSrcM = 1).
//   - Required: SP = DEPTH = 256, ErrM = 0, StackEmpty = 1 immediately, before the next edge.
//  T2 Normal store/load
//   - Stimulus: MemSrcM = 0, MemWriteM = 1, ALUResultM = 0x0000_0010, WriteDataM = 0xDEAD_BEEF; next cycle, read the same address.
//   - Required: ReadDataM = 0xDEAD_BEEF. Address 0x0000_0410 aliases to the same word.
//  T3 Push/pop order
//   - Stimulus: push 0x11, then 0x22.
//   - Required: SP = 254. Pops return 0x22, then 0x11; SP = 256; StackEmpty = 1.
//  T4 Overflow
//   - Stimulus: 256 pushes, then a 257th push.
//   - Required: StackFull = 1 and SP = 0 after 256 pushes. After the 257th, SP stays 0, RAM[0] is unchanged, ErrM = 3'b001.
//  T5 Underflow and conflict
//   - Stimulus: pop on an empty stack.
//   - Required: ReadDataM = 0, ErrM[1] = 1.
//   - Stimulus: PushM = PopM = 1.
//   - Required: SP unchanged, ErrM = 3'b110.
//   - Stimulus: ErrClr.
//   - Required: ErrM = 0.
//  T6 Clear vs. set race
//   - Stimulus: ErrClr = 1 in the same cycle as an overflow push.
//   - Required: ErrM = 3'b001 afterwards.

Source files
------------

// File: rtl/mem_stage_stack_unit_if.sv
// MEM-stage data-memory bus: EX/MEM controls and operands in, read data,
// stack pointer, stack flags and sticky stack-error bits out.
interface mem_stage_stack_unit_if #(
  parameter int ADDR_W = 8
);
  logic [31:0]     ALUResultM;
  logic [31:0]     WriteDataM;
  logic            MemWriteM;
  logic            PushM;
  logic            PopM;
  logic            MemSrcM;
  logic            ErrClr;
  logic [31:0]     ReadDataM;
  logic [ADDR_W:0] SPM;
  logic            StackFull;
  logic            StackEmpty;
  logic [2:0]      ErrM;

  // Pipeline side: drives controls and operands, observes results
  modport master (
    output ALUResultM, WriteDataM, MemWriteM, PushM, PopM, MemSrcM, ErrClr,
    input  ReadDataM, SPM, StackFull, StackEmpty, ErrM
  );

  // Memory stage side: consumes controls and operands, produces results
  modport slave (
    input  ALUResultM, WriteDataM, MemWriteM, PushM, PopM, MemSrcM, ErrClr,
    output ReadDataM, SPM, StackFull, StackEmpty, ErrM
  );
endinterface

// File: rtl/mem_stage_stack_unit.sv
// MEM-stage data-memory front end: word-addressed data RAM plus a
// full-descending hardware stack. SP points at the last pushed word and
// SP == DEPTH means empty, so SP carries one extra bit. Stack faults are
// accumulated as sticky {conflict, underflow, overflow} bits.
module mem_stage_stack_unit #(
  parameter int ADDR_W = 8
) (
  input  logic                   CLK,
  input  logic                   reset,
  mem_stage_stack_unit_if.slave  bus
);

  localparam int              DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W:0] SP_EMPTY = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] SP_FULL  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] SP_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  logic [31:0]       r_mem [DEPTH];
  logic [ADDR_W:0]   r_sp;
  logic [2:0]        r_err;

  logic              w_full;
  logic              w_empty;
  logic              w_push_op;
  logic              w_pop_op;
  logic              w_conflict;
  logic              w_overflow;
  logic              w_underflow;
  logic              w_we;
  logic [ADDR_W:0]   w_sp_dec;
  logic [ADDR_W:0]   w_sp_inc;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W:0]   w_sp_next;
  logic [2:0]        w_err_set;
  logic [2:0]        w_err_next;
  logic [31:0]       w_rdata;
  logic              w_unused_alu;

  // Byte-offset and out-of-range address bits are deliberately dropped (wrap)
  assign w_unused_alu = ^{bus.ALUResultM[31:ADDR_W+2], bus.ALUResultM[1:0]};

  assign w_full   = (r_sp == SP_FULL);
  assign w_empty  = (r_sp == SP_EMPTY);
  assign w_sp_dec = r_sp - SP_ONE;
  assign w_sp_inc = r_sp + SP_ONE;

  // Stack operations exist only with stack addressing; push+pop together is a conflict
  assign w_push_op   = bus.MemSrcM & bus.PushM & ~bus.PopM;
  assign w_pop_op    = bus.MemSrcM & bus.PopM  & ~bus.PushM;
  assign w_conflict  = bus.MemSrcM & bus.PushM &  bus.PopM;
  assign w_overflow  = w_push_op & w_full;
  assign w_underflow = w_pop_op  & w_empty;
  assign w_err_set   = {w_conflict, w_underflow, w_overflow};

  // Normal stores only under ALU addressing; pushes only when there is room
  assign w_we = (~bus.MemSrcM & bus.MemWriteM) | (w_push_op & ~w_full);

  // Word address select: ALU word address, pre-decremented SP for push, SP otherwise
  always_comb begin
    w_addr = r_sp[ADDR_W-1:0];
    if (!bus.MemSrcM) begin
      w_addr = bus.ALUResultM[ADDR_W+1:2];
    end else if (w_push_op) begin
      w_addr = w_sp_dec[ADDR_W-1:0];
    end else begin
      w_addr = r_sp[ADDR_W-1:0];
    end
  end

  // Zero-latency read; a pop from an empty stack yields zero instead of stale data
  always_comb begin
    w_rdata = r_mem[w_addr];
    if (w_underflow) begin
      w_rdata = 32'h0000_0000;
    end else begin
      w_rdata = r_mem[w_addr];
    end
  end

  // Next stack pointer: successful push moves down, successful pop moves up
  always_comb begin
    w_sp_next = r_sp;
    if (w_push_op && !w_full) begin
      w_sp_next = w_sp_dec;
    end else if (w_pop_op && !w_empty) begin
      w_sp_next = w_sp_inc;
    end else begin
      w_sp_next = r_sp;
    end
  end

  // Sticky error update: a new fault in the clearing cycle survives the clear
  always_comb begin
    w_err_next = r_err | w_err_set;
    if (bus.ErrClr) begin
      w_err_next = w_err_set;
    end else begin
      w_err_next = r_err | w_err_set;
    end
  end

  // RAM write port; contents are never reset, and a write during reset is dropped
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      // hold contents while reset is asserted
    end else if (w_we) begin
      r_mem[w_addr] <= bus.WriteDataM;
    end
  end

  // Stack pointer register, empty after reset
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_sp <= SP_EMPTY;
    end else begin
      r_sp <= w_sp_next;
    end
  end

  // Sticky error register, cleared by reset
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_err <= 3'b000;
    end else begin
      r_err <= w_err_next;
    end
  end

  assign bus.ReadDataM  = w_rdata;
  assign bus.SPM        = r_sp;
  assign bus.StackFull  = w_full;
  assign bus.StackEmpty = w_empty;
  assign bus.ErrM       = r_err;

endmodule

// File: tb/tb_mem_stage_stack_unit.sv
// Self-checking bench for mem_stage_stack_unit: expected read data is queued
// when each access is driven and compared when the DUT presents it.
module tb_mem_stage_stack_unit;

  logic CLK;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  mem_stage_stack_unit_if #(.ADDR_W(8)) bus();

  mem_stage_stack_unit #(.ADDR_W(8)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Apply one cycle's controls just after the falling edge, then let them settle
  task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic we,
                       input logic push, input logic pop, input logic src, input logic clr);
    @(negedge CLK);
    bus.ALUResultM = alu;
    bus.WriteDataM = wd;
    bus.MemWriteM  = we;
    bus.PushM      = push;
    bus.PopM       = pop;
    bus.MemSrcM    = src;
    bus.ErrClr     = clr;
    #1;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (bus.SPM !== 9'd256) begin n_fail++; $display("FAIL reset_sp: got %0d expected 256", bus.SPM); end
    n_checks++; if (bus.StackEmpty !== 1'b1 || bus.StackFull !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got empty=%b full=%b expected empty=1 full=0", bus.StackEmpty, bus.StackFull); end
    step();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    // first push completes normally: RAM[255] = 0xAA
    drive(32'h0, 32'h0000_00AA, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    n_checks++; if (bus.SPM !== 9'd255) begin n_fail++; $display("FAIL reset_pre_push_sp: got %0d expected 255", bus.SPM); end
    // second push interrupted by reset mid-cycle
    drive(32'h0, 32'h0000_00BB, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    n_checks++; if (bus.SPM !== 9'd256) begin n_fail++; $display("FAIL reset_async_sp: got %0d expected 256", bus.SPM); end
    n_checks++; if (bus.ErrM !== 3'b000) begin n_fail++; $display("FAIL reset_async_err: got %b expected 000", bus.ErrM); end
    n_checks++; if (bus.StackEmpty !== 1'b1) begin n_fail++; $display("FAIL reset_async_empty: got %b expected 1", bus.StackEmpty); end
    step();
    drive(32'h0000_03FC, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    // word 255 must still hold the first push; the push during reset was discarded
    exp_q.push_back(32'h0000_00AA);
    #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (bus.ReadDataM !== exp_v) begin n_fail++; $display("FAIL reset_write_discard: got %h expected %h", bus.ReadDataM, exp_v); end
    step();
  endtask

  task automatic test_store_load();
    drive(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(32'h0000_0010, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(32'hDEAD_BEEF);
    exp_v = exp_q.pop_front();
    n_checks++; if (bus.ReadDataM !== exp_v) begin n_fail++; $display("FAIL store_load: got %h expected %h", bus.ReadDataM, exp_v); end
    drive(32'h0000_0410, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(32'hDEAD_BEEF);
    exp_v = exp_q.pop_front();
    n_checks++; if (bus.ReadDataM !== exp_v) begin n_fail++; $display("FAIL store_alias: got %h expected %h", bus.ReadDataM, exp_v); end
    // ALU addressing ignores push/pop: store lands, SP untouched
    drive(32'h0000_0023, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    n_checks++; if (bus.SPM !== 9'd256) begin n_fail++; $display("FAIL store_push_ignored: got sp %0d expected 256", bus.SPM); end
    drive(32'h0000_0020, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(32'h1234_5678);
    exp_v = exp_q.pop_front();
    n_checks++; if (bus.ReadDataM !== exp_v) begin n_fail++; $display("FAIL store_byte_offset: got %h expected %h", bus.ReadDataM, exp_v); end
  endtask

  task automatic test_push_pop();
    drive(32'h0, 32'h0000_0011, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    drive(32'h0, 32'h0000_0022, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    n_checks++; if (bus.SPM !== 9'd254) begin n_fail++; $display("FAIL push_sp: got %0d expected 254", bus.SPM); end
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(32'h0000_0022);
    exp_v = exp_q.pop_front();
    n_checks++; if (bus.ReadDataM !== exp_v) begin n_fail++; $display("FAIL pop_first: got %h expected %h", bus.ReadDataM, exp_v); end
    step();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(32'h0000_0011);
    exp_v = exp_q.pop_front();
    n_checks++; if (bus.ReadDataM !== exp_v) begin n_fail++; $display("FAIL pop_second: got %h expected %h", bus.ReadDataM, exp_v); end
    step();
    n_checks++; if (bus.SPM !== 9'd256 || bus.StackEmpty !== 1'b1) begin n_fail++; $display("FAIL pop_empty_state: got sp %0d empty %b expected 256 1", bus.SPM, bus.StackEmpty); end
    n_checks++; if (bus.ErrM !== 3'b000) begin n_fail++; $display("FAIL push_pop_err: got %b expected 000", bus.ErrM); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(32'h0, 32'hA5A5_0000 + 32'(i), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      exp_q.push_back(32'hA5A5_0000 + 32'(i));
      step();
      drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      exp_v = exp_q.pop_front();
      n_checks++; if (bus.ReadDataM !== exp_v) begin n_fail++; $display("FAIL b2b_pop_%0d: got %h expected %h", i, bus.ReadDataM, exp_v); end
      step();
      n_checks++; if (bus.SPM !== 9'd256) begin n_fail++; $display("FAIL b2b_sp_%0d: got %0d expected 256", i, bus.SPM); end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 256; i++) begin
      drive(32'h0, 32'h0000_1000 + 32'(i), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      n_checks++; if (bus.SPM !== 9'(255 - i)) begin n_fail++; $display("FAIL fill_sp_%0d: got %0d expected %0d", i, bus.SPM, 255 - i); end
    end
    n_checks++; if (bus.StackFull !== 1'b1 || bus.StackEmpty !== 1'b0) begin n_fail++; $display("FAIL full_flag: got full %b empty %b expected 1 0", bus.StackFull, bus.StackEmpty); end
    drive(32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    n_checks++; if (bus.SPM !== 9'd0) begin n_fail++; $display("FAIL overflow_sp: got %0d expected 0", bus.SPM); end
    n_checks++; if (bus.ErrM !== 3'b001) begin n_fail++; $display("FAIL overflow_err: got %b expected 001", bus.ErrM); end
    drive(32'h0000_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(32'h0000_10FF);
    exp_v = exp_q.pop_front();
    n_checks++; if (bus.ReadDataM !== exp_v) begin n_fail++; $display("FAIL overflow_ram0: got %h expected %h", bus.ReadDataM, exp_v); end
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    n_checks++; if (bus.ErrM !== 3'b000) begin n_fail++; $display("FAIL overflow_clr: got %b expected 000", bus.ErrM); end
  endtask

  task automatic test_clr_race();
    drive(32'h0, 32'h5555_5555, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    n_checks++; if (bus.ErrM !== 3'b001) begin n_fail++; $display("FAIL clr_race_err: got %b expected 001", bus.ErrM); end
    n_checks++; if (bus.SPM !== 9'd0) begin n_fail++; $display("FAIL clr_race_sp: got %0d expected 0", bus.SPM); end
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    n_checks++; if (bus.ErrM !== 3'b000) begin n_fail++; $display("FAIL clr_race_clear: got %b expected 000", bus.ErrM); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 256; i++) begin
      drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      exp_q.push_back(32'h0000_10FF - 32'(i));
      exp_v = exp_q.pop_front();
      n_checks++; if (bus.ReadDataM !== exp_v) begin n_fail++; $display("FAIL drain_data_%0d: got %h expected %h", i, bus.ReadDataM, exp_v); end
      step();
      n_checks++; if (bus.SPM !== 9'(i + 1)) begin n_fail++; $display("FAIL drain_sp_%0d: got %0d expected %0d", i, bus.SPM, i + 1); end
    end
  endtask

  task automatic test_underflow_conflict();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(32'h0000_0000);
    exp_v = exp_q.pop_front();
    n_checks++; if (bus.ReadDataM !== exp_v) begin n_fail++; $display("FAIL underflow_data: got %h expected %h", bus.ReadDataM, exp_v); end
    step();
    n_checks++; if (bus.ErrM !== 3'b010) begin n_fail++; $display("FAIL underflow_err: got %b expected 010", bus.ErrM); end
    n_checks++; if (bus.SPM !== 9'd256) begin n_fail++; $display("FAIL underflow_sp: got %0d expected 256", bus.SPM); end
    drive(32'h0, 32'h7777_7777, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(32'h0000_10FF);
    exp_v = exp_q.pop_front();
    n_checks++; if (bus.ReadDataM !== exp_v) begin n_fail++; $display("FAIL conflict_data: got %h expected %h", bus.ReadDataM, exp_v); end
    step();
    n_checks++; if (bus.SPM !== 9'd256) begin n_fail++; $display("FAIL conflict_sp: got %0d expected 256", bus.SPM); end
    n_checks++; if (bus.ErrM !== 3'b110) begin n_fail++; $display("FAIL conflict_err: got %b expected 110", bus.ErrM); end
    drive(32'h0000_03FC, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(32'h0000_1000);
    exp_v = exp_q.pop_front();
    n_checks++; if (bus.ReadDataM !== exp_v) begin n_fail++; $display("FAIL conflict_no_write: got %h expected %h", bus.ReadDataM, exp_v); end
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    n_checks++; if (bus.ErrM !== 3'b000) begin n_fail++; $display("FAIL errclr: got %b expected 000", bus.ErrM); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.ALUResultM = 32'h0;
    bus.WriteDataM = 32'h0;
    bus.MemWriteM  = 1'b0;
    bus.PushM      = 1'b0;
    bus.PopM       = 1'b0;
    bus.MemSrcM    = 1'b0;
    bus.ErrClr     = 1'b0;
    reset          = 1'b0;
    test_reset();
    test_store_load();
    test_push_pop();
    test_back_to_back();
    test_overflow();
    test_clr_race();
    test_drain();
    test_underflow_conflict();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
